rgb_fader: RTL and testbench

Parametrised successor to the fixed 3-channel LED PWM. Drives nch independent PWM channels with full 0..100% duty range and glitch-free duty updates applied only at PWM period boundaries. New targets arrive via valid/ready handshake and are applied immediately or as a linear fade. Outputs are raw PWM lines that feed the board LED driver or GPIO pads.

---
 rtl/rgb_fader.sv | 177 +++++++++++++++++
 tb/tb_rgb_fader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fader.sv
// rgb_fader: nch-channel PWM generator with glitch-free duty updates.
//
// A free-running counter (0..max-1, period = max clocks) drives every channel.
// Each channel output is high while cnt < cur[i], so cur = 0 is constant low and
// cur = max is constant high. New duty targets are taken through a valid/ready
// handshake and applied either in one step (mode 0) or as a linear fade
// (mode 1). Duties only ever change on the period boundary, so no PWM period
// is ever truncated or stretched.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           run enable; low freezes counter/fade and forces pwm_o low
//   tgt_i        packed target duties, channel i at [(i+1)*nbpc-1:i*nbpc]
//   mode_i       0 = apply at next boundary, 1 = fade
//   tgt_valid_i  target offered
//   tgt_ready_o  high only while idle (registered)
//   pwm_o        registered PWM lines
//   busy_o       high while a target is pending or fading
//   done_o       one-cycle pulse when the duties reach the accepted target
module rgb_fader #(
    parameter int nch      = 3,
    parameter int nbpc     = 8,
    parameter int step     = 1,
    parameter int ramp_div = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [nch*nbpc-1:0]   tgt_i,
    input  logic                  mode_i,
    input  logic                  tgt_valid_i,
    output logic                  tgt_ready_o,
    output logic [nch-1:0]        pwm_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int max_duty = 2**nbpc - 1;
    localparam logic [nbpc-1:0] cnt_last = nbpc'(max_duty - 1);
    localparam int dw = (ramp_div > 1) ? $clog2(ramp_div) : 1;
    localparam logic [dw-1:0] div_last = dw'(ramp_div - 1);
    // Step in both the duty width and the one-bit-wider difference width.
    localparam logic [nbpc-1:0] step_n = nbpc'(step);
    localparam logic [nbpc:0]   step_w = (nbpc + 1)'(step);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RAMP
    } state_t;

    state_t            state_reg;
    logic [nbpc-1:0]   cnt_reg;
    logic [dw-1:0]     div_reg;
    logic [nbpc-1:0]   cur_reg [nch];
    logic [nbpc-1:0]   tgt_reg [nch];
    logic [nch-1:0]    pwm_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              ready_reg;

    logic [nbpc-1:0]   tgt_in   [nch];
    logic [nbpc-1:0]   cur_next [nch];
    logic [nch-1:0]    pwm_next;
    logic [nch-1:0]    ch_eq;
    logic              pb;
    logic              accept;
    logic              all_eq;

    assign pb     = en && (cnt_reg == cnt_last);
    assign accept = tgt_valid_i && ready_reg;
    assign all_eq = &ch_eq;

    generate
        for (genvar gi = 0; gi < nch; gi++) begin : gen_ch
            logic [nbpc:0] up_d;
            logic [nbpc:0] dn_d;

            assign tgt_in[gi] = tgt_i[gi*nbpc +: nbpc];

            // Zero-extended differences cannot wrap; only the one matching
            // the direction of travel is meaningful.
            assign up_d = {1'b0, tgt_reg[gi]} - {1'b0, cur_reg[gi]};
            assign dn_d = {1'b0, cur_reg[gi]} - {1'b0, tgt_reg[gi]};

            // Snap to target when within one step, so the fade never overshoots.
            assign cur_next[gi] = (tgt_reg[gi] >= cur_reg[gi])
                ? ((up_d <= step_w) ? tgt_reg[gi] : cur_reg[gi] + step_n)
                : ((dn_d <= step_w) ? tgt_reg[gi] : cur_reg[gi] - step_n);

            assign ch_eq[gi]    = (cur_next[gi] == tgt_reg[gi]);
            assign pwm_next[gi] = en && (cnt_reg < cur_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            div_reg   <= '0;
            pwm_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
            for (int i = 0; i < nch; i++) begin
                cur_reg[i] <= '0;
                tgt_reg[i] <= '0;
            end
        end else begin
            pwm_reg  <= pwm_next;
            done_reg <= 1'b0;

            if (en) begin
                cnt_reg <= pb ? '0 : cnt_reg + nbpc'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    // A boundary coinciding with the accept is deliberately
                    // not used: the pending state waits for the next one.
                    if (accept) begin
                        for (int i = 0; i < nch; i++) begin
                            tgt_reg[i] <= tgt_in[i];
                        end
                        div_reg   <= '0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= mode_i ? ST_RAMP : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (pb) begin
                        for (int i = 0; i < nch; i++) begin
                            cur_reg[i] <= tgt_reg[i];
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_RAMP: begin
                    if (pb) begin
                        if (div_reg == div_last) begin
                            div_reg <= '0;
                            for (int i = 0; i < nch; i++) begin
                                cur_reg[i] <= cur_next[i];
                            end
                            if (all_eq) begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                ready_reg <= 1'b1;
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            div_reg <= div_reg + dw'(1);
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwm_o       = pwm_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign tgt_ready_o = ready_reg;

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader. Instance A: 3 channels, 4 bits, step 1,
// ramp_div 2. Instance B: 1 channel, 4 bits, step 4, ramp_div 1.
// Duties are observed by counting pwm high cycles over one 15-clock period
// aligned to the period boundary.
module tb_rgb_fader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic [11:0] tgt_a;
    logic        mode_a;
    logic        valid_a;
    logic        ready_a;
    logic [2:0]  pwm_a;
    logic        busy_a;
    logic        done_a;

    logic [3:0]  tgt_b;
    logic        mode_b;
    logic        valid_b;
    logic        ready_b;
    logic [0:0]  pwm_b;
    logic        busy_b;
    logic        done_b;

    int n_checks = 0;
    int n_errors = 0;

    // Boundary tracker derived from the counter definition (period 15 clocks).
    int   ref_cnt;
    logic last_pb;

    always #5 clk = ~clk;

    rgb_fader #(.nch(3), .nbpc(4), .step(1), .ramp_div(2)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tgt_i       (tgt_a),
        .mode_i      (mode_a),
        .tgt_valid_i (valid_a),
        .tgt_ready_o (ready_a),
        .pwm_o       (pwm_a),
        .busy_o      (busy_a),
        .done_o      (done_a)
    );

    rgb_fader #(.nch(1), .nbpc(4), .step(4), .ramp_div(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tgt_i       (tgt_b),
        .mode_i      (mode_b),
        .tgt_valid_i (valid_b),
        .tgt_ready_o (ready_b),
        .pwm_o       (pwm_b),
        .busy_o      (busy_b),
        .done_o      (done_b)
    );

    always @(posedge clk) begin
        if (rst) begin
            ref_cnt <= 0;
            last_pb <= 1'b0;
        end else begin
            last_pb <= en && (ref_cnt == 14);
            if (en) ref_cnt <= (ref_cnt == 14) ? 0 : ref_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge just after the next boundary edge; counts
    // activity on the samples before it.
    task automatic wait_pb(output int ha, output int hb, output int da, output int db);
        bit hit;
        hit = 0; ha = 0; hb = 0; da = 0; db = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (last_pb) hit = 1;
            else begin
                ha += $countones(pwm_a);
                hb += int'(pwm_b);
                da += int'(done_a);
                db += int'(done_b);
            end
        end
        if (!hit) chk("wait_pb_timeout", 0, 1);
    endtask

    // Advance to the negedge right before a boundary edge.
    task automatic wait_pre();
        bit hit;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (ref_cnt == 14) hit = 1;
        end
        if (!hit) chk("wait_pre_timeout", 0, 1);
    endtask

    // One full period starting from a boundary-aligned negedge.
    task automatic measure(output int h0, output int h1, output int h2,
                           output int hb, output int da, output int db);
        h0 = 0; h1 = 0; h2 = 0; hb = 0; da = 0; db = 0;
        repeat (15) begin
            @(negedge clk);
            h0 += int'(pwm_a[0]);
            h1 += int'(pwm_a[1]);
            h2 += int'(pwm_a[2]);
            hb += int'(pwm_b);
            da += int'(done_a);
            db += int'(done_b);
        end
    endtask

    task automatic offer_a(input logic [11:0] t, input logic m);
        tgt_a = t; mode_a = m; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        $display("txn A tgt=%03h mode=%0d busy=%0d", t, m, busy_a);
    endtask

    task automatic offer_b(input logic [3:0] t, input logic m);
        tgt_b = t; mode_b = m; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        $display("txn B tgt=%0h mode=%0d busy=%0d", t, m, busy_b);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, hb, da, db, ha, n;

        // Reset with a target offered: nothing may be accepted.
        rst = 1'b1; en = 1'b1;
        tgt_a = 12'hFFF; mode_a = 1'b0; valid_a = 1'b1;
        tgt_b = 4'h0; mode_b = 1'b0; valid_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pwm", int'(pwm_a), 0);
            chk("rst_ready", int'(ready_a), 0);
            chk("rst_busy", int'(busy_a), 0);
        end
        rst = 1'b0; valid_a = 1'b0;
        @(negedge clk);
        chk("rel_ready", int'(ready_a), 1);
        chk("rel_busy", int'(busy_a), 0);

        // Immediate apply: ch2=5 ch1=15 ch0=0.
        offer_a(12'h5F0, 1'b0);
        chk("imm_busy", int'(busy_a), 1);
        chk("imm_ready", int'(ready_a), 0);
        wait_pb(ha, hb, da, db);
        chk("imm_pre_pwm", ha, 0);
        chk("imm_pre_done", da, 0);
        chk("imm_done", int'(done_a), 1);
        chk("imm_ready_back", int'(ready_a), 1);
        chk("imm_busy_clr", int'(busy_a), 0);
        measure(h0, h1, h2, hb, da, db);
        chk("imm_ch0", h0, 0);
        chk("imm_ch1", h1, 15);
        chk("imm_ch2", h2, 5);
        chk("imm_post_done", da, 0);

        // Fade ch0 0->3, with a competing offer held while busy.
        offer_a(12'h5F3, 1'b1);
        chk("fup_busy", int'(busy_a), 1);
        wait_pb(ha, hb, da, db);
        tgt_a = 12'h000; mode_a = 1'b0; valid_a = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            measure(h0, h1, h2, hb, da, db);
            chk($sformatf("fup_w%0d_ch0", w), h0, (w == 1) ? 0 : (w <= 3) ? 1 : 2);
            chk($sformatf("fup_w%0d_done", w), da, 0);
            chk($sformatf("fup_w%0d_ready", w), int'(ready_a), 0);
        end
        valid_a = 1'b0;
        measure(h0, h1, h2, hb, da, db);
        chk("fup_w5_ch0", h0, 2);
        chk("fup_w5_done", da, 1);
        chk("fup_end_busy", int'(busy_a), 0);
        chk("fup_end_ready", int'(ready_a), 1);
        measure(h0, h1, h2, hb, da, db);
        chk("fup_w6_ch0", h0, 3);
        chk("fup_w6_ch1", h1, 15);
        chk("fup_w6_ch2", h2, 5);

        // Accept coinciding with a boundary: applied one period later.
        wait_pre();
        offer_a(12'hF07, 1'b0);
        chk("cpb_busy", int'(busy_a), 1);
        chk("cpb_done", int'(done_a), 0);
        measure(h0, h1, h2, hb, da, db);
        chk("cpb_old_ch0", h0, 3);
        chk("cpb_old_ch1", h1, 15);
        chk("cpb_old_ch2", h2, 5);
        chk("cpb_done_cnt", da, 1);
        measure(h0, h1, h2, hb, da, db);
        chk("cpb_new_ch0", h0, 7);
        chk("cpb_new_ch1", h1, 0);
        chk("cpb_new_ch2", h2, 15);

        // Fade ch0 7->4 with en dropped for 40 cycles mid-fade.
        offer_a(12'hF04, 1'b1);
        wait_pb(ha, hb, da, db);
        measure(h0, h1, h2, hb, da, db);
        chk("en_w1_ch0", h0, 7);
        repeat (5) @(negedge clk);
        en = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n += $countones(pwm_a);
        end
        chk("en_low_pwm", n, 0);
        chk("en_low_busy", int'(busy_a), 1);
        en = 1'b1;
        wait_pb(ha, hb, da, db);
        chk("en_resume_done", da, 0);
        measure(h0, h1, h2, hb, da, db);
        chk("en_w3_ch0", h0, 6);
        measure(h0, h1, h2, hb, da, db);
        chk("en_w4_ch0", h0, 5);
        measure(h0, h1, h2, hb, da, db);
        chk("en_w5_ch0", h0, 5);
        chk("en_w5_done", da, 1);
        measure(h0, h1, h2, hb, da, db);
        chk("en_w6_ch0", h0, 4);
        chk("en_w6_ch2", h2, 15);

        // Instance B: set 15 then fade down to 2 with step 4.
        offer_b(4'hF, 1'b0);
        chk("b_imm_busy", int'(busy_b), 1);
        wait_pb(ha, hb, da, db);
        chk("b_imm_done", int'(done_b), 1);
        measure(h0, h1, h2, hb, da, db);
        chk("b_imm_duty", hb, 15);
        offer_b(4'h2, 1'b1);
        wait_pb(ha, hb, da, db);
        for (int w = 1; w <= 4; w++) begin
            measure(h0, h1, h2, hb, da, db);
            chk($sformatf("b_fdn_w%0d_duty", w), hb, (w == 1) ? 11 : (w == 2) ? 7 : (w == 3) ? 3 : 2);
            chk($sformatf("b_fdn_w%0d_done", w), db, (w == 3) ? 1 : 0);
        end

        // Reset in the middle of a fade on A.
        offer_a(12'hFF4, 1'b1);
        wait_pb(ha, hb, da, db);
        wait_pb(ha, hb, da, db);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_pwm", int'(pwm_a), 0);
            chk("mrst_busy", int'(busy_a), 0);
            chk("mrst_done", int'(done_a), 0);
            chk("mrst_ready", int'(ready_a), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rel_ready", int'(ready_a), 1);
        chk("mrst_rel_busy", int'(busy_a), 0);
        wait_pb(ha, hb, da, db);
        chk("mrst_pre_done", da, 0);
        chk("mrst_pb_done", int'(done_a), 0);
        measure(h0, h1, h2, hb, da, db);
        chk("mrst_ch0", h0, 0);
        chk("mrst_ch1", h1, 0);
        chk("mrst_ch2", h2, 0);
        chk("mrst_b", hb, 0);
        chk("mrst_win_done", da, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
